// File: rtl/ifft_ctrl_pkg.sv
// Shared constants, types and FSM states for the 128-point IFFT stage sequencer.
package ifft_ctrl_pkg;

    localparam int unsigned N       = 128;
    localparam int unsigned LOG2N   = 7;
    localparam int unsigned HALF_N  = N / 2;
    localparam int unsigned STAGE_W = 3;

    typedef logic [LOG2N-1:0]   addr_t;
    typedef logic [LOG2N-2:0]   tw_idx_t;
    typedef logic [LOG2N-2:0]   k_t;
    typedef logic [STAGE_W-1:0] stage_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/ifft_bf_addr_gen.sv
// Combinational radix-2 DIT butterfly address generator.
// Maps butterfly index k within a stage to its two RAM legs and twiddle index.
module ifft_bf_addr_gen
    import ifft_ctrl_pkg::*;
(
    input  k_t      i_k,
    input  stage_t  i_stage,
    output addr_t   o_addr_a,
    output addr_t   o_addr_b,
    output tw_idx_t o_tw_idx
);

    addr_t w_k_ext;
    addr_t w_span;
    addr_t w_pos;
    addr_t w_addr_a;

    // Split k into group number (upper bits) and offset within the group (lower bits)
    always_comb begin
        w_k_ext  = addr_t'(i_k);
        w_span   = addr_t'(1) << i_stage;
        w_pos    = w_k_ext & (w_span - addr_t'(1));
        // Groups are 2*span apart; the upper leg sits at the group base plus the offset
        w_addr_a = ((w_k_ext >> i_stage) << (i_stage + stage_t'(1))) | w_pos;
        o_addr_a = w_addr_a;
        o_addr_b = w_addr_a + w_span;
        // pos < span, so the shifted value always fits in N/2 entries
        o_tw_idx = tw_idx_t'(w_pos << (stage_t'(LOG2N - 1) - i_stage));
    end

endmodule

// File: rtl/ifft_stage_sched.sv
// Stage/butterfly sequencer for the in-place radix-2 DIT 128-point IFFT.
// Optional feature macro: FFT_MODE_EN adds i_inv_n (direction, latched at start) and
// o_tw_conj (asks the datapath to negate the imaginary twiddle term for a forward FFT).
module ifft_stage_sched
    import ifft_ctrl_pkg::*;
#(
    parameter int unsigned BF_LAT = 4
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_start,
    input  logic    i_bf_ready,
`ifdef FFT_MODE_EN
    input  logic    i_inv_n,
    output logic    o_tw_conj,
`endif
    output logic    o_busy,
    output logic    o_done,
    output logic    o_bf_valid,
    output addr_t   o_addr_a,
    output addr_t   o_addr_b,
    output tw_idx_t o_tw_idx,
    output stage_t  o_stage,
    output logic    o_stage_last
);

    localparam int unsigned DRAIN_W = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    typedef logic [DRAIN_W-1:0] drain_t;

    localparam drain_t DRAIN_LAST = drain_t'(BF_LAT - 1);
    localparam k_t     K_LAST     = k_t'(HALF_N - 1);
    localparam stage_t STAGE_LAST = stage_t'(LOG2N - 1);

    sched_state_t r_state, w_state_d;
    k_t           r_k, w_k_d;
    stage_t       r_stage, w_stage_d;
    drain_t       r_drain_cnt, w_drain_d;

    logic    w_accept;
    logic    w_run_d;
    addr_t   w_gen_a;
    addr_t   w_gen_b;
    tw_idx_t w_gen_tw;

    logic    r_busy;
    logic    r_done;
    logic    r_bf_valid;
    logic    r_stage_last;
    addr_t   r_addr_a;
    addr_t   r_addr_b;
    tw_idx_t r_tw_idx;

    assign w_accept = r_bf_valid & i_bf_ready;
    assign w_run_d  = (w_state_d == RUN);

    // Next state: FSM transitions, butterfly index advance and drain countdown
    always_comb begin
        w_state_d = r_state;
        w_k_d     = r_k;
        w_stage_d = r_stage;
        w_drain_d = r_drain_cnt;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_d = RUN;
                    w_k_d     = '0;
                    w_stage_d = '0;
                end
            end
            RUN: begin
                if (w_accept) begin
                    if (r_k == K_LAST) begin
                        w_state_d = DRAIN;
                        w_k_d     = '0;
                        w_drain_d = '0;
                    end else begin
                        w_k_d = r_k + k_t'(1);
                    end
                end
            end
            DRAIN: begin
                // Runs regardless of bf_ready: in-flight butterflies always complete
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_drain_d = '0;
                    if (r_stage == STAGE_LAST) begin
                        w_state_d = DONE;
                    end else begin
                        w_state_d = RUN;
                        w_stage_d = r_stage + stage_t'(1);
                    end
                end else begin
                    w_drain_d = r_drain_cnt + drain_t'(1);
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // Addresses are computed from next-state k/stage so they can be registered with bf_valid
    ifft_bf_addr_gen u_addr_gen (
        .i_k      (w_k_d),
        .i_stage  (w_stage_d),
        .o_addr_a (w_gen_a),
        .o_addr_b (w_gen_b),
        .o_tw_idx (w_gen_tw)
    );

    // Sequencer state registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_stage     <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_d;
            r_k         <= w_k_d;
            r_stage     <= w_stage_d;
            r_drain_cnt <= w_drain_d;
        end
    end

    // Registered outputs; address fields read as zero whenever no butterfly is offered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_bf_valid   <= 1'b0;
            r_addr_a     <= '0;
            r_addr_b     <= '0;
            r_tw_idx     <= '0;
            r_stage_last <= 1'b0;
        end else begin
            r_busy       <= (w_state_d != IDLE);
            r_done       <= (w_state_d == DONE);
            r_bf_valid   <= w_run_d;
            r_addr_a     <= w_run_d ? w_gen_a : '0;
            r_addr_b     <= w_run_d ? w_gen_b : '0;
            r_tw_idx     <= w_run_d ? w_gen_tw : '0;
            r_stage_last <= w_run_d && (w_k_d == K_LAST);
        end
    end

`ifdef FFT_MODE_EN
    logic r_inv_n;
    logic w_inv_d;
    logic r_tw_conj;

    assign w_inv_d = ((r_state == IDLE) && i_start) ? i_inv_n : r_inv_n;

    // Direction is captured once per transform; tw_conj is qualified by bf_valid
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inv_n   <= 1'b0;
            r_tw_conj <= 1'b0;
        end else begin
            r_inv_n   <= w_inv_d;
            r_tw_conj <= w_run_d & ~w_inv_d;
        end
    end

    assign o_tw_conj = r_tw_conj;
`endif

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_bf_valid   = r_bf_valid;
    assign o_addr_a     = r_addr_a;
    assign o_addr_b     = r_addr_b;
    assign o_tw_idx     = r_tw_idx;
    assign o_stage      = r_stage;
    assign o_stage_last = r_stage_last;

endmodule

// File: tb/tb_ifft_stage_sched.sv
// Self-checking bench for ifft_stage_sched: reset abort, full runs, backpressure,
// restart rules, and a butterfly-list reference model built from the DIT loop nest.
module tb_ifft_stage_sched;
    import ifft_ctrl_pkg::*;

    localparam int unsigned BF_LAT   = 4;
    localparam int          DONE_LAT = LOG2N * (HALF_N + BF_LAT) + 1;
    localparam int          BUDGET   = 4000;

    typedef struct packed {
        logic [2:0] stage;
        logic [6:0] a;
        logic [6:0] b;
        logic [5:0] tw;
        logic       last;
    } bf_t;

    logic    i_clk = 1'b0;
    logic    i_rst;
    logic    i_start;
    logic    i_bf_ready;
    logic    o_busy;
    logic    o_done;
    logic    o_bf_valid;
    addr_t   o_addr_a;
    addr_t   o_addr_b;
    tw_idx_t o_tw_idx;
    stage_t  o_stage;
    logic    o_stage_last;
`ifdef FFT_MODE_EN
    logic    i_inv_n;
    logic    o_tw_conj;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bf_t exp_q[$];

    ifft_stage_sched #(.BF_LAT(BF_LAT)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_bf_ready   (i_bf_ready),
`ifdef FFT_MODE_EN
        .i_inv_n      (i_inv_n),
        .o_tw_conj    (o_tw_conj),
`endif
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_bf_valid   (o_bf_valid),
        .o_addr_a     (o_addr_a),
        .o_addr_b     (o_addr_b),
        .o_tw_idx     (o_tw_idx),
        .o_stage      (o_stage),
        .o_stage_last (o_stage_last)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({o_busy, o_done, o_bf_valid, o_addr_a, o_addr_b, o_tw_idx, o_stage,
                    o_stage_last});
    endfunction

    function automatic bf_t observed();
        bf_t o;
        o.stage = o_stage;
        o.a     = o_addr_a;
        o.b     = o_addr_b;
        o.tw    = o_tw_idx;
        o.last  = o_stage_last;
        return o;
    endfunction

    // Textbook DIT loop nest: groups of 2*half, twiddle stride N/(2*half)
    function automatic void build_model();
        bf_t e;
        int  k;
        exp_q.delete();
        for (int s = 0; s < int'(LOG2N); s++) begin
            int half = 1 << s;
            k = 0;
            for (int g = 0; g < int'(N); g += 2 * half) begin
                for (int j = 0; j < half; j++) begin
                    e.stage = 3'(s);
                    e.a     = 7'(g + j);
                    e.b     = 7'(g + j + half);
                    e.tw    = 6'(j * (int'(N) / (2 * half)));
                    e.last  = (k == int'(HALF_N) - 1);
                    exp_q.push_back(e);
                    k++;
                end
            end
        end
    endfunction

    task automatic run_transform(input bit rnd_ready, input int pulse_at, input bit start_in_done,
                                 input bit inv);
        int  cyc;
        int  done_cyc;
        int  last_acc;
        int  acc_idx;
        int  gap_starts;
        int  invalid_cnt;
        int  pat_err;
        int  busy_err;
        int  conj_err;
        int  ones;
        bit  prev_valid;
        bit  exp_valid;
        bf_t obs;
        bf_t s2k5;
        bf_t s6k63;
        int  hits[LOG2N][N];

        for (int s = 0; s < int'(LOG2N); s++)
            for (int a = 0; a < int'(N); a++) hits[s][a] = 0;
        build_model();
        done_cyc = -1; last_acc = -100; acc_idx = 0; gap_starts = 0; invalid_cnt = 0;
        pat_err = 0; busy_err = 0; conj_err = 0; prev_valid = 1'b1;
        s2k5 = '0; s6k63 = '0;

        i_start = 1'b1;
`ifdef FFT_MODE_EN
        i_inv_n = inv;
`endif
        step();
        i_start = 1'b0;
        cyc = 1;
        while (cyc <= BUDGET) begin
            if (o_busy !== 1'b1) busy_err++;
            if (o_done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            i_start = (pulse_at != 0) && (cyc == pulse_at || cyc == pulse_at + 34);
            if (!rnd_ready) begin
                exp_valid = ((cyc - 1) % int'(HALF_N + BF_LAT)) < int'(HALF_N);
                if (o_bf_valid !== exp_valid) pat_err++;
            end
            obs = observed();
            if (o_bf_valid === 1'b1) begin
                if (exp_q.size() == 0) check("extra_butterfly", 1, 0);
                else check("butterfly", obs, exp_q[0]);
`ifdef FFT_MODE_EN
                if (o_tw_conj !== ~inv) conj_err++;
`endif
            end else begin
                invalid_cnt++;
                if (prev_valid) gap_starts++;
            end
            prev_valid = o_bf_valid;
            i_bf_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_bf_valid === 1'b1 && i_bf_ready && exp_q.size() != 0) begin
                hits[obs.stage][obs.a]++;
                hits[obs.stage][obs.b]++;
                if (acc_idx == 2 * int'(HALF_N) + 5) s2k5 = obs;
                if (acc_idx == 6 * int'(HALF_N) + 63) s6k63 = obs;
                acc_idx++;
                last_acc = cyc;
                void'(exp_q.pop_front());
            end
            step();
            cyc++;
        end

        check("done_seen", done_cyc > 0, 1);
        if (!rnd_ready) begin
            check("done_latency", done_cyc, DONE_LAT);
            check("valid_pattern", pat_err, 0);
        end
        check("done_after_last_accept", done_cyc - last_acc, BF_LAT + 1);
        check("butterflies_left", exp_q.size(), 0);
        check("accepts", acc_idx, LOG2N * HALF_N);
        check("gap_count", gap_starts, LOG2N);
        check("gap_cycles", invalid_cnt, LOG2N * BF_LAT);
        check("busy_during_run", busy_err, 0);
`ifdef FFT_MODE_EN
        check("tw_conj", conj_err, 0);
`endif
        check("s2k5_addr_a", s2k5.a, 9);
        check("s2k5_addr_b", s2k5.b, 13);
        check("s2k5_tw_idx", s2k5.tw, 16);
        check("s6k63_addr_a", s6k63.a, 63);
        check("s6k63_addr_b", s6k63.b, 127);
        check("s6k63_tw_idx", s6k63.tw, 63);
        check("s6k63_last", s6k63.last, 1);
        for (int s = 0; s < int'(LOG2N); s++) begin
            ones = 0;
            for (int a = 0; a < int'(N); a++) if (hits[s][a] == 1) ones++;
            check($sformatf("coverage_stage%0d", s), ones, N);
        end

        // Leave the DONE cycle, optionally with start held, and expect a quiet IDLE cycle
        i_start = start_in_done;
        step();
        i_start = 1'b0;
        check("done_one_cycle", o_done, 0);
        check("idle_busy", o_busy, 0);
        check("idle_no_restart", o_bf_valid, 0);
    endtask

    initial begin
        int idle_err;
        i_rst      = 1'b1;
        i_start    = 1'b0;
        i_bf_ready = 1'b0;
`ifdef FFT_MODE_EN
        i_inv_n    = 1'b1;
`endif
        repeat (3) step();
        check("reset_outputs", outs(), 0);
        i_rst = 1'b0;
        step();
        check("idle_after_reset", outs(), 0);

        // Abort mid-run with a 3-cycle reset
        i_start = 1'b1;
        step();
        i_start    = 1'b0;
        i_bf_ready = 1'b1;
        repeat (30) step();
        check("running_before_abort", o_bf_valid, 1);
        i_rst = 1'b1;
        step();
        check("abort_outputs", outs(), 0);
        step();
        step();
        i_rst = 1'b0;
        idle_err = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (outs() !== 32'd0) idle_err++;
        end
        check("idle_after_abort", idle_err, 0);

        // Full run, ready high, start pulsed in DRAIN and RUN and in the DONE cycle
        run_transform(1'b0, 66, 1'b1, 1'b1);
        // Started one cycle after DONE, random backpressure, forward direction
        run_transform(1'b1, 0, 1'b0, 1'b0);
        // Back-to-back again with ready high
        run_transform(1'b0, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
